// File: rtl/data_ram_axi_slave.sv
// Responder for the Data RAM window at 0x2000_0000: pairs independent write
// address/data handshakes into word commits and serves reads at fixed latency.
module data_ram_axi_slave #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ramAxiWriteAddress,
    input  logic        ramAxiWriteValid,
    output logic        ramAxiWriteReady,
    input  logic [31:0] ramAxiWriteData,
    input  logic        ramAxiWriteValidData,
    output logic        ramAxiWriteReadyData,
    input  logic [31:0] ramAxiReadAddress,
    input  logic        ramAxiReadValid,
    output logic        ramAxiReadReady,
    output logic [31:0] ramAxiReadData,
    output logic        ramAxiReadValidData,
    input  logic        ramAxiReadReadyData,
    output logic        accessError
);
    // state   | meaning
    // RD_IDLE | address channel open, no read in flight
    // RD_WAIT | latency timer counting down toward the data sample
    // RD_RESP | response valid, held until the master accepts it

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    function automatic logic in_window(input logic [31:2] a);
        return (a[31:29] == 3'b001) && (a[28:AW+2] == '0);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic        aw_held, w_held;
    logic [31:2] aw_addr_q;
    logic [31:0] w_data_q;
    logic        aw_hs, w_hs, ar_hs, rsp_hs;
    logic        commit, commit_in_win, mem_we;
    logic [31:2] commit_addr;
    logic [31:0] commit_data;

    rd_state_t   rd_state, rd_next;
    logic [31:2] rd_addr_q;
    logic [1:0]  rd_cnt;
    logic        sample;
    logic [31:2] sample_addr;
    logic [31:0] sample_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{ramAxiWriteAddress[1:0], ramAxiReadAddress[1:0]};

    assign ramAxiWriteReady     = !aw_held;
    assign ramAxiWriteReadyData = !w_held;

    assign aw_hs  = ramAxiWriteValid && ramAxiWriteReady;
    assign w_hs   = ramAxiWriteValidData && ramAxiWriteReadyData;
    assign ar_hs  = ramAxiReadValid && ramAxiReadReady;
    assign rsp_hs = ramAxiReadValidData && ramAxiReadReadyData;

    // A commit needs one side arriving now and the other either arriving or held.
    assign commit        = (aw_hs && w_hs) || (aw_hs && w_held) || (w_hs && aw_held);
    assign commit_addr   = aw_held ? aw_addr_q : ramAxiWriteAddress[31:2];
    assign commit_data   = w_held ? w_data_q : ramAxiWriteData;
    assign commit_in_win = in_window(commit_addr);
    assign mem_we        = commit && commit_in_win && !reset;

    always_comb begin
        rd_next             = rd_state;
        ramAxiReadReady     = 1'b0;
        ramAxiReadValidData = 1'b0;
        sample              = 1'b0;
        sample_addr         = rd_addr_q;
        case (rd_state)
            RD_IDLE: begin
                ramAxiReadReady = 1'b1;
                sample_addr     = ramAxiReadAddress[31:2];
                if (ar_hs) begin
                    if (READ_LATENCY == 1) begin
                        rd_next = RD_RESP;
                        sample  = 1'b1;
                    end else begin
                        rd_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt == 2'd1) begin
                    rd_next = RD_RESP;
                    sample  = 1'b1;
                end
            end
            RD_RESP: begin
                ramAxiReadValidData = 1'b1;
                if (rsp_hs) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Write-first: a commit landing on the sampling edge is forwarded.
    always_comb begin
        sample_data = 32'h0;
        if (in_window(sample_addr)) begin
            if (mem_we && (commit_addr[AW+1:2] == sample_addr[AW+1:2]))
                sample_data = commit_data;
            else
                sample_data = mem[sample_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            aw_addr_q      <= '0;
            w_data_q       <= '0;
            rd_addr_q      <= '0;
            rd_cnt         <= '0;
            ramAxiReadData <= '0;
            accessError    <= 1'b0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
            if (aw_hs) aw_addr_q <= ramAxiWriteAddress[31:2];
            if (w_hs)  w_data_q  <= ramAxiWriteData;
            if (ar_hs) begin
                rd_addr_q <= ramAxiReadAddress[31:2];
                rd_cnt    <= 2'(READ_LATENCY - 1);
            end else if (rd_state == RD_WAIT) begin
                rd_cnt <= rd_cnt - 2'd1;
            end
            if (sample) ramAxiReadData <= sample_data;
            if ((commit && !commit_in_win) ||
                (ar_hs && !in_window(ramAxiReadAddress[31:2])))
                accessError <= 1'b1;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[commit_addr[AW+1:2]] <= commit_data;
    end

endmodule

// File: tb/tb_data_ram_axi_slave.sv
// Directed bench: one instance at read latency 1 (1024 words) and one at
// read latency 3 (16 words), exercised in a single linear sequence.
module tb_data_ram_axi_slave;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
    logic        a_wvalid, a_wready, a_wdvalid, a_wdready;
    logic        a_rvalid, a_rready, a_dvalid, a_rdready, a_err;

    logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;
    logic        b_wvalid, b_wready, b_wdvalid, b_wdready;
    logic        b_rvalid, b_rready, b_dvalid, b_rdready, b_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    data_ram_axi_slave #(.DEPTH_WORDS(1024), .READ_LATENCY(1)) dut_a (
        .clock(clk), .reset(rst),
        .ramAxiWriteAddress(a_waddr), .ramAxiWriteValid(a_wvalid), .ramAxiWriteReady(a_wready),
        .ramAxiWriteData(a_wdata), .ramAxiWriteValidData(a_wdvalid), .ramAxiWriteReadyData(a_wdready),
        .ramAxiReadAddress(a_raddr), .ramAxiReadValid(a_rvalid), .ramAxiReadReady(a_rready),
        .ramAxiReadData(a_rdata), .ramAxiReadValidData(a_dvalid), .ramAxiReadReadyData(a_rdready),
        .accessError(a_err)
    );

    data_ram_axi_slave #(.DEPTH_WORDS(16), .READ_LATENCY(3)) dut_b (
        .clock(clk), .reset(rst),
        .ramAxiWriteAddress(b_waddr), .ramAxiWriteValid(b_wvalid), .ramAxiWriteReady(b_wready),
        .ramAxiWriteData(b_wdata), .ramAxiWriteValidData(b_wdvalid), .ramAxiWriteReadyData(b_wdready),
        .ramAxiReadAddress(b_raddr), .ramAxiReadValid(b_rvalid), .ramAxiReadReady(b_rready),
        .ramAxiReadData(b_rdata), .ramAxiReadValidData(b_dvalid), .ramAxiReadReadyData(b_rdready),
        .accessError(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data);
        a_waddr = addr; a_wdata = data; a_wvalid = 1'b1; a_wdvalid = 1'b1;
        tick();
        a_wvalid = 1'b0; a_wdvalid = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        a_raddr = addr; a_rvalid = 1'b1;
        tick();
        a_rvalid = 1'b0;
        check({tag, "_valid"}, a_dvalid, 1);
        check({tag, "_data"}, a_rdata, exp);
        a_rdready = 1'b1;
        tick();
        a_rdready = 1'b0;
    endtask

    task automatic write_b(input logic [31:0] addr, input logic [31:0] data);
        b_waddr = addr; b_wdata = data; b_wvalid = 1'b1; b_wdvalid = 1'b1;
        tick();
        b_wvalid = 1'b0; b_wdvalid = 1'b0;
    endtask

    task automatic read_b(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        b_raddr = addr; b_rvalid = 1'b1;
        tick();
        b_rvalid = 1'b0;
        check({tag, "_early"}, b_dvalid, 0);
        tick();
        tick();
        check({tag, "_valid"}, b_dvalid, 1);
        check({tag, "_data"}, b_rdata, exp);
        b_rdready = 1'b1;
        tick();
        b_rdready = 1'b0;
    endtask

    initial begin
        a_waddr = '0; a_wdata = '0; a_raddr = '0;
        a_wvalid = 0; a_wdvalid = 0; a_rvalid = 0; a_rdready = 0;
        b_waddr = '0; b_wdata = '0; b_raddr = '0;
        b_wvalid = 0; b_wdvalid = 0; b_rvalid = 0; b_rdready = 0;

        #1 rst = 1'b1;
        #1;
        check("rst_wready", a_wready, 1);
        check("rst_wdready", a_wdready, 1);
        check("rst_rready", a_rready, 1);
        check("rst_dvalid", a_dvalid, 0);
        check("rst_rdata", a_rdata, 32'h0);
        check("rst_err", a_err, 0);
        check("rst_b_rready", b_rready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // paired write, then read two cycles later
        a_waddr = 32'h2000_0010; a_wdata = 32'hCAFE_F00D; a_wvalid = 1; a_wdvalid = 1;
        check("pair_wready_c0", a_wready, 1);
        check("pair_wdready_c0", a_wdready, 1);
        tick();
        a_wvalid = 0; a_wdvalid = 0;
        check("pair_wready_c1", a_wready, 1);
        check("pair_wdready_c1", a_wdready, 1);
        tick();
        a_raddr = 32'h2000_0010; a_rvalid = 1;
        check("pair_rready_c2", a_rready, 1);
        tick();
        a_rvalid = 0;
        check("pair_dvalid_c3", a_dvalid, 1);
        check("pair_rdata_c3", a_rdata, 32'hCAFE_F00D);
        check("pair_rready_c3", a_rready, 0);
        a_rdready = 1;
        tick();
        a_rdready = 0;
        check("pair_dvalid_c4", a_dvalid, 0);
        check("pair_rready_c4", a_rready, 1);

        // split write: address first, data three cycles later
        a_waddr = 32'h2000_0004; a_wvalid = 1;
        tick();
        a_wvalid = 0;
        check("split_wready_c1", a_wready, 0);
        check("split_wdready_c1", a_wdready, 1);
        tick();
        check("split_wready_c2", a_wready, 0);
        tick();
        check("split_wready_c3", a_wready, 0);
        a_wdata = 32'h1234_5678; a_wdvalid = 1;
        tick();
        a_wdvalid = 0;
        check("split_wready_c4", a_wready, 1);
        check("split_wdready_c4", a_wdready, 1);
        read_a("split_rd", 32'h2000_0004, 32'h1234_5678);

        // split write: data first
        a_wdata = 32'h0BAD_BEEF; a_wdvalid = 1;
        tick();
        a_wdvalid = 0;
        check("dfirst_wdready", a_wdready, 0);
        check("dfirst_wready", a_wready, 1);
        a_waddr = 32'h2000_0008; a_wvalid = 1;
        tick();
        a_wvalid = 0;
        check("dfirst_wdready_after", a_wdready, 1);
        read_a("dfirst_rd", 32'h2000_0008, 32'h0BAD_BEEF);
        read_a("pair_still", 32'h2000_0010, 32'hCAFE_F00D);

        // forwarding: write and read of the same word in one cycle
        a_waddr = 32'h2000_0020; a_wdata = 32'hAAAA_5555; a_wvalid = 1; a_wdvalid = 1;
        a_raddr = 32'h2000_0020; a_rvalid = 1;
        tick();
        a_wvalid = 0; a_wdvalid = 0; a_rvalid = 0;
        check("fwd_dvalid", a_dvalid, 1);
        check("fwd_rdata", a_rdata, 32'hAAAA_5555);
        a_rdready = 1;
        tick();
        a_rdready = 0;

        // out-of-window accesses
        write_a(32'h2000_0040, 32'h5A5A_0001);
        write_a(32'h2000_0000, 32'h1111_2222);
        check("oow_err_before", a_err, 0);
        write_a(32'h0000_0040, 32'hFFFF_FFFF);
        check("oow_err_after_wr", a_err, 1);
        read_a("oow_unchanged", 32'h2000_0040, 32'h5A5A_0001);
        read_a("oow_rd_4000", 32'h4000_0000, 32'h0);
        read_a("oow_rd_hibits", 32'h2000_1000, 32'h0);
        read_a("oow_alias_ok", 32'h2000_0000, 32'h1111_2222);
        check("oow_err_sticky", a_err, 1);

        // latency 3 with response backpressure and edge forwarding
        write_b(32'h2000_000C, 32'h3C3C_3C3C);
        b_raddr = 32'h2000_000C; b_rvalid = 1;
        check("bp_rready_c0", b_rready, 1);
        tick();
        b_rvalid = 0;
        check("bp_rready_c1", b_rready, 0);
        check("bp_dvalid_c1", b_dvalid, 0);
        tick();
        check("bp_dvalid_c2", b_dvalid, 0);
        b_waddr = 32'h2000_000C; b_wdata = 32'h7777_0000; b_wvalid = 1; b_wdvalid = 1;
        tick();
        check("bp_dvalid_c3", b_dvalid, 1);
        check("bp_rdata_c3", b_rdata, 32'h7777_0000);
        b_wdata = 32'h8888_0000;
        tick();
        b_wvalid = 0; b_wdvalid = 0;
        for (int c = 4; c <= 7; c++) begin
            check($sformatf("bp_rdata_c%0d", c), b_rdata, 32'h7777_0000);
            check($sformatf("bp_dvalid_c%0d", c), b_dvalid, 1);
            check($sformatf("bp_rready_c%0d", c), b_rready, 0);
            if (c == 7) b_rdready = 1;
            tick();
        end
        b_rdready = 0;
        check("bp_rready_c8", b_rready, 1);
        check("bp_dvalid_c8", b_dvalid, 0);
        read_b("bp_later", 32'h2000_000C, 32'h8888_0000);
        read_b("b_oow", 32'h2000_0040, 32'h0);
        check("b_err_set", b_err, 1);

        // reset with a held write address and a read in the wait state
        write_b(32'h2000_0014, 32'h5555_AAAA);
        b_waddr = 32'h2000_0014; b_wvalid = 1;
        b_raddr = 32'h2000_0014; b_rvalid = 1;
        tick();
        b_wvalid = 0; b_rvalid = 0;
        check("mid_wready_held", b_wready, 0);
        check("mid_rready_wait", b_rready, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_wready", b_wready, 1);
        check("mid_rst_wdready", b_wdready, 1);
        check("mid_rst_rready", b_rready, 1);
        check("mid_rst_dvalid", b_dvalid, 0);
        check("mid_rst_rdata", b_rdata, 32'h0);
        check("mid_rst_b_err", b_err, 0);
        check("mid_rst_a_err", a_err, 0);
        #2 rst = 1'b0;
        tick();
        b_wdata = 32'h9999_9999; b_wdvalid = 1;
        tick();
        b_wdvalid = 0;
        check("mid_no_resp", b_dvalid, 0);
        read_b("mid_no_commit", 32'h2000_0014, 32'h5555_AAAA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
